// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : connect4_pkg
// Description : Shared constants and FSM state encoding for the Connect-4
//               player input front end.
// Revision    : 1.0 - initial release
// ============================================================================
package connect4_pkg;

    // Default board width and the width of the binary column bus
    localparam int NUM_COLS = 4;
    localparam int COL_W    = 4;

    // Input controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DROP     = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_LOCKED   = 2'd3
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/column_input_controller_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser, stable-level debounce counter and
//               rising-edge detector for one raw push button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_q;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the debounced level
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb_q <= 1'b0;
        end else begin
            r_deb_q <= r_deb;
        end
    end

    assign level = r_deb;
    assign rise  = r_deb & ~r_deb_q;

endmodule
`default_nettype wire

// File: rtl/column_input_controller.sv
`default_nettype none
// ============================================================================
// Module      : column_input_controller
// Description : Connect-4 player front end. Debounces left/right/drop
//               buttons, keeps a wrap-around column cursor and issues a
//               single-cycle drop request (or reject on a full column).
//               All input is locked out once the game is over.
// Revision    : 1.0 - initial release
// ============================================================================
module column_input_controller #(
    parameter int NUM_COLS        = connect4_pkg::NUM_COLS,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_drop,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                game_over,
    output logic [3:0]          sel_column,
    output logic [NUM_COLS-1:0] cursor_onehot,
    output logic                drop_pulse,
    output logic                reject,
    output logic                busy
);

    import connect4_pkg::*;

    localparam int                C_CUR_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [C_CUR_W-1:0] C_CUR_MAX = C_CUR_W'(NUM_COLS - 1);

    logic w_left_level;
    logic w_left_rise;
    logic w_right_level;
    logic w_right_rise;
    logic w_drop_level;
    logic w_drop_rise;
    logic w_unused_levels;

    ctrl_state_t        r_state;
    ctrl_state_t        w_state_nxt;
    logic [C_CUR_W-1:0] r_cursor;
    logic [C_CUR_W-1:0] w_cursor_nxt;
    logic               r_drop_pulse;
    logic               w_drop_pulse_nxt;
    logic               r_reject;
    logic               w_reject_nxt;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_left (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_left),
        .level(w_left_level),
        .rise (w_left_rise)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_right (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_right),
        .level(w_right_level),
        .rise (w_right_rise)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_drop (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_drop),
        .level(w_drop_level),
        .rise (w_drop_rise)
    );

    // Only edges of the move buttons matter; their levels are intentionally unused
    assign w_unused_levels = w_left_level ^ w_right_level;

    // State, cursor and pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cursor     <= '0;
            r_drop_pulse <= 1'b0;
            r_reject     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cursor     <= w_cursor_nxt;
            r_drop_pulse <= w_drop_pulse_nxt;
            r_reject     <= w_reject_nxt;
        end
    end

    // Next-state logic: game_over overrides everything, drop beats moves,
    // opposing moves in the same cycle cancel out
    always_comb begin
        w_state_nxt      = r_state;
        w_cursor_nxt     = r_cursor;
        w_drop_pulse_nxt = 1'b0;
        w_reject_nxt     = 1'b0;

        if (game_over) begin
            w_state_nxt = ST_LOCKED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_drop_rise) begin
                        if (col_full[r_cursor]) begin
                            w_reject_nxt = 1'b1;
                        end else begin
                            w_state_nxt      = ST_DROP;
                            w_drop_pulse_nxt = 1'b1;
                        end
                    end else if (w_left_rise && !w_right_rise) begin
                        w_cursor_nxt = (r_cursor == '0) ? C_CUR_MAX : r_cursor - 1'b1;
                    end else if (w_right_rise && !w_left_rise) begin
                        w_cursor_nxt = (r_cursor == C_CUR_MAX) ? '0 : r_cursor + 1'b1;
                    end
                end
                ST_DROP: begin
                    w_state_nxt = ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!w_drop_level) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOCKED;
                end
            endcase
        end
    end

    assign sel_column    = COL_W'(r_cursor);
    assign cursor_onehot = NUM_COLS'(1) << r_cursor;
    assign drop_pulse    = r_drop_pulse;
    assign reject        = r_reject;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_column_input_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_column_input_controller
// Description : Directed self-checking bench for column_input_controller
//               with a scoreboard of expected drop/reject pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_column_input_controller;

    logic       clk;
    logic       reset;
    logic       btn_left;
    logic       btn_right;
    logic       btn_drop;
    logic [3:0] col_full;
    logic       game_over;
    logic [3:0] sel_column;
    logic [3:0] cursor_onehot;
    logic       drop_pulse;
    logic       reject;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;
    int n_rejects = 0;

    logic [3:0] q_drop[$];
    logic [3:0] q_rej[$];
    logic [3:0] r_prev_sel;
    logic       r_prev_pulse;
    logic [3:0] r_pulse_sel;

    column_input_controller #(
        .NUM_COLS       (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_drop     (btn_drop),
        .col_full     (col_full),
        .game_over    (game_over),
        .sel_column   (sel_column),
        .cursor_onehot(cursor_onehot),
        .drop_pulse   (drop_pulse),
        .reject       (reject),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic l, input logic r, input logic d, input int hold);
        btn_left  = l;
        btn_right = r;
        btn_drop  = d;
        cyc(hold);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        cyc(12);
    endtask

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] v;
        v = 4'b0001;
        return v << k;
    endfunction

    // Scoreboard: every observed pulse must match a queued expectation, and
    // sel_column must be stable across the cycles around a drop pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (r_prev_pulse) begin
                check("sel_after_drop", sel_column, r_pulse_sel);
            end
            if (drop_pulse) begin
                n_pulses++;
                check("sel_before_drop", sel_column, r_prev_sel);
                if (q_drop.size() == 0) check("unexpected_drop", 1, 0);
                else check("drop_col", sel_column, q_drop.pop_front());
            end
            if (reject) begin
                n_rejects++;
                if (q_rej.size() == 0) check("unexpected_reject", 1, 0);
                else check("reject_col", sel_column, q_rej.pop_front());
            end
        end
        r_prev_sel   <= sel_column;
        r_prev_pulse <= drop_pulse && !reset;
        r_pulse_sel  <= sel_column;
    end

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses_before;
        int rej_before;

        reset     = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        col_full  = 4'b0000;
        game_over = 1'b0;
        cyc(3);

        // Reset state
        check("rst_sel", sel_column, 0);
        check("rst_onehot", cursor_onehot, 4'b0001);
        check("rst_drop", drop_pulse, 0);
        check("rst_reject", reject, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        cyc(2);

        // 1: right presses walk the cursor and wrap
        for (int k = 1; k <= 4; k++) begin
            press(1'b0, 1'b1, 1'b0, 10);
            check("right_sel", sel_column, k % 4);
            check("right_onehot", cursor_onehot, onehot(k % 4));
        end

        // 2: left wraps 0 -> 3; a 2-cycle glitch is filtered
        press(1'b1, 1'b0, 1'b0, 10);
        check("left_wrap_sel", sel_column, 3);
        check("left_wrap_onehot", cursor_onehot, 4'b1000);
        press(1'b0, 1'b1, 1'b0, 2);
        check("glitch_sel", sel_column, 3);

        // 3: long drop hold on column 2 gives a single pulse
        press(1'b1, 1'b0, 1'b0, 10);
        check("left_to_2", sel_column, 2);
        pulses_before = n_pulses;
        q_drop.push_back(4'd2);
        btn_drop = 1'b1;
        cyc(20);
        check("hold_one_pulse", n_pulses, pulses_before + 1);
        check("hold_busy", busy, 1);
        check("hold_sel", sel_column, 2);
        btn_drop = 1'b0;
        cyc(6);
        check("busy_before_release_seen", busy, 1);
        cyc(1);
        check("busy_after_release", busy, 0);
        cyc(5);

        // 4: drop on a full column rejects
        press(1'b1, 1'b0, 1'b0, 10);
        check("left_to_1", sel_column, 1);
        col_full      = 4'b0010;
        pulses_before = n_pulses;
        rej_before    = n_rejects;
        q_rej.push_back(4'd1);
        press(1'b0, 1'b0, 1'b1, 10);
        check("full_no_pulse", n_pulses, pulses_before);
        check("full_one_reject", n_rejects, rej_before + 1);
        check("full_busy", busy, 0);
        col_full = 4'b0000;

        // 5: simultaneous drop+right: drop wins, cursor unchanged
        press(1'b1, 1'b0, 1'b0, 10);
        check("left_to_0", sel_column, 0);
        pulses_before = n_pulses;
        q_drop.push_back(4'd0);
        press(1'b0, 1'b1, 1'b1, 10);
        check("prio_one_pulse", n_pulses, pulses_before + 1);
        check("prio_sel", sel_column, 0);
        check("prio_idle", busy, 0);

        // 5b: game over locks everything
        game_over = 1'b1;
        cyc(2);
        check("locked_busy", busy, 1);
        pulses_before = n_pulses;
        press(1'b0, 1'b0, 1'b1, 10);
        press(1'b0, 1'b1, 1'b0, 10);
        check("locked_no_pulse", n_pulses, pulses_before);
        check("locked_sel", sel_column, 0);
        check("locked_onehot", cursor_onehot, 4'b0001);

        // 6: reset in WAIT_REL with drop held
        reset = 1'b1;
        cyc(2);
        reset     = 1'b0;
        game_over = 1'b0;
        cyc(2);
        press(1'b0, 1'b1, 1'b0, 10);
        check("pre6_sel", sel_column, 1);
        q_drop.push_back(4'd1);
        btn_drop = 1'b1;
        cyc(12);
        check("wait_rel_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_sel", sel_column, 0);
        check("mid_rst_onehot", cursor_onehot, 4'b0001);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop", drop_pulse, 0);
        cyc(2);
        pulses_before = n_pulses;
        q_drop.push_back(4'd0);
        reset = 1'b0;
        cyc(6);
        check("held_no_early_pulse", drop_pulse, 0);
        cyc(1);
        check("held_pulse_on_time", drop_pulse, 1);
        cyc(5);
        check("held_one_pulse", n_pulses, pulses_before + 1);
        check("held_wait_rel", busy, 1);
        btn_drop = 1'b0;
        cyc(12);
        check("final_idle", busy, 0);
        check("drop_q_empty", q_drop.size(), 0);
        check("rej_q_empty", q_rej.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
